// File: rtl/mips_line_fill.sv
// Instruction-cache line refill engine: fetches a 16-byte line word by word and presents it with a
// one-cycle LineValid pulse. Define MIPS_LINE_FILL_CRITICAL_WORD_FIRST_EN for critical-word-first.
module mips_line_fill #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                                     clockPulse,
    input  logic                                     reset,
    input  logic                                     MissReq,
    input  logic [ADDR_W-1:0]                        MissAddress,
    output logic                                     Busy,
    output logic                                     MemReadReq,
    output logic [ADDR_W-1:0]                        MemAddress,
    input  logic [31:0]                              MemData,
    input  logic                                     MemAck,
    output logic [32*LINE_WORDS-1:0]                 DataLine,
    output logic [ADDR_W-$clog2(4*LINE_WORDS)-1:0]   LineTag,
    output logic                                     LineValid
`ifdef MIPS_LINE_FILL_CRITICAL_WORD_FIRST_EN
    ,
    output logic                                     CritValid,
    output logic [31:0]                              CritWord
`endif
);

    localparam int unsigned OFF_W = $clog2(4 * LINE_WORDS);
    localparam int unsigned CNT_W = OFF_W - 2;
    localparam int unsigned TAG_W = ADDR_W - OFF_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    state_e                       r_state;
    state_e                       w_state_nxt;
    logic [CNT_W-1:0]             r_cnt;
    logic [CNT_W-1:0]             r_idx;
    logic [CNT_W-1:0]             w_idx_nxt;
    logic [CNT_W-1:0]             w_first;
    logic [TAG_W-1:0]             r_tag;
    logic [ADDR_W-1:0]            r_mem_addr;
    logic [LINE_WORDS-1:0][31:0]  r_words;
    logic                         w_accept;
    logic                         w_ack;
    logic                         w_last;
    logic                         w_unused_offset;

    assign w_accept  = (r_state == StIdle) && MissReq;
    assign w_ack     = (r_state == StFill) && MemAck;
    assign w_last    = (r_cnt == LAST);
    assign w_idx_nxt = r_idx + CNT_W'(1);

`ifdef MIPS_LINE_FILL_CRITICAL_WORD_FIRST_EN
    assign w_first         = MissAddress[OFF_W-1:2];
    assign w_unused_offset = ^MissAddress[1:0];
`else
    assign w_first         = '0;
    assign w_unused_offset = ^MissAddress[OFF_W-1:0];
`endif

    always_ff @(posedge clockPulse) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (MissReq) w_state_nxt = StFill;
            StFill:  if (w_ack && w_last) w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        Busy       = 1'b0;
        MemReadReq = 1'b0;
        LineValid  = 1'b0;
        unique case (r_state)
            StFill: begin
                Busy       = 1'b1;
                MemReadReq = 1'b1;
            end
            StDone: begin
                Busy      = 1'b1;
                LineValid = 1'b1;
            end
            default: ;
        endcase
    end

    // Slot index wraps inside the line, so the tag never carries into the upper address bits.
    always_ff @(posedge clockPulse) begin
        if (reset) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_tag      <= '0;
            r_mem_addr <= '0;
            r_words    <= '0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_idx      <= w_first;
            r_tag      <= MissAddress[ADDR_W-1:OFF_W];
            r_mem_addr <= {MissAddress[ADDR_W-1:OFF_W], w_first, 2'b00};
        end else if (w_ack) begin
            r_words[r_idx] <= MemData;
            r_cnt          <= r_cnt + CNT_W'(1);
            r_idx          <= w_idx_nxt;
            if (!w_last) begin
                r_mem_addr <= {r_tag, w_idx_nxt, 2'b00};
            end
        end
    end

    assign MemAddress = r_mem_addr;
    assign DataLine   = r_words;
    assign LineTag    = r_tag;

`ifdef MIPS_LINE_FILL_CRITICAL_WORD_FIRST_EN
    logic        r_crit_valid;
    logic [31:0] r_crit_word;

    always_ff @(posedge clockPulse) begin
        if (reset) begin
            r_crit_valid <= 1'b0;
            r_crit_word  <= '0;
        end else begin
            r_crit_valid <= w_ack && (r_cnt == '0);
            if (w_ack && (r_cnt == '0)) begin
                r_crit_word <= MemData;
            end
        end
    end

    assign CritValid = r_crit_valid;
    assign CritWord  = r_crit_word;
`endif

endmodule

// File: tb/tb_mips_line_fill.sv
// Directed self-checking bench for mips_line_fill; memory returns byte-address patterns.
module tb_mips_line_fill;

    localparam int ADDR_W     = 32;
    localparam int LINE_WORDS = 4;
    localparam logic [127:0] LINE_00 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] LINE_10 = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
    localparam logic [127:0] LINE_60 = 128'h6F6E6D6C_6B6A6968_67666564_63626160;

    logic          clk = 1'b0;
    logic          rst;
    logic          MissReq;
    logic [31:0]   MissAddress;
    logic          Busy;
    logic          MemReadReq;
    logic [31:0]   MemAddress;
    logic [31:0]   MemData;
    logic          MemAck;
    logic [127:0]  DataLine;
    logic [27:0]   LineTag;
    logic          LineValid;
`ifdef MIPS_LINE_FILL_CRITICAL_WORD_FIRST_EN
    logic          CritValid;
    logic [31:0]   CritWord;
`endif

    logic [3:0]    wait_n = 4'd0;
    logic [3:0]    wcnt = 4'd0;
    logic          stray_ack = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc;

    mips_line_fill #(
        .ADDR_W     (ADDR_W),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clockPulse  (clk),
        .reset       (rst),
        .MissReq     (MissReq),
        .MissAddress (MissAddress),
        .Busy        (Busy),
        .MemReadReq  (MemReadReq),
        .MemAddress  (MemAddress),
        .MemData     (MemData),
        .MemAck      (MemAck),
        .DataLine    (DataLine),
        .LineTag     (LineTag),
        .LineValid   (LineValid)
`ifdef MIPS_LINE_FILL_CRITICAL_WORD_FIRST_EN
        ,
        .CritValid   (CritValid),
        .CritWord    (CritWord)
`endif
    );

    always #5 clk = ~clk;

    // Memory: word at byte address a holds bytes a+3..a; acks after wait_n request cycles.
    assign MemData = {MemAddress[7:0] + 8'd3, MemAddress[7:0] + 8'd2,
                      MemAddress[7:0] + 8'd1, MemAddress[7:0]};
    assign MemAck  = (MemReadReq && (wcnt == wait_n)) || stray_ack;

    always @(posedge clk) begin
        if (!MemReadReq || MemAck) wcnt <= 4'd0;
        else                       wcnt <= wcnt + 4'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] miss, input int k);
        int w;
        w = 0;
`ifdef MIPS_LINE_FILL_CRITICAL_WORD_FIRST_EN
        w = int'(miss[3:2]);
`endif
        return {miss[31:4], 4'b0000} + 32'(((w + k) % 4) * 4);
    endfunction

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 1;
        while (LineValid !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        rst = 1'b1;
        MissReq = 1'b0;
        MissAddress = 32'h0;

        // Reset and idle
        tick();
        tick();
        check("rst_busy", Busy, 0);
        check("rst_req", MemReadReq, 0);
        check("rst_addr", MemAddress, 0);
        check("rst_line", DataLine, 0);
        check("rst_tag", LineTag, 0);
        check("rst_lv", LineValid, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_req", MemReadReq, 0);
        end
        stray_ack = 1'b1;
        tick();
        tick();
        stray_ack = 1'b0;
        tick();
        check("stray_line", DataLine, 0);
        check("stray_busy", Busy, 0);

        // Zero-wait fill; MissAddress changes after acceptance
        MissAddress = 32'h5;
        MissReq = 1'b1;
        tick();
        MissReq = 1'b0;
        MissAddress = 32'hFFFF_FFF0;
        for (int k = 0; k < 4; k++) begin
            check("zw_busy", Busy, 1);
            check("zw_req", MemReadReq, 1);
            check("zw_addr", MemAddress, exp_addr(32'h5, k));
            check("zw_lv", LineValid, 0);
            tick();
        end
        check("zw_lv5", LineValid, 1);
        check("zw_busy5", Busy, 1);
        check("zw_req5", MemReadReq, 0);
        check("zw_line", DataLine, LINE_00);
        check("zw_tag", LineTag, 0);
        tick();
        check("zw_lv6", LineValid, 0);
        check("zw_busy6", Busy, 0);
        check("zw_hold", DataLine, LINE_00);

        // Two wait cycles per word
        wait_n = 4'd2;
        MissAddress = 32'h1A;
        MissReq = 1'b1;
        tick();
        MissReq = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            check("ws_busy", Busy, 1);
            check("ws_req", MemReadReq, 1);
            check("ws_addr", MemAddress, exp_addr(32'h1A, (c - 1) / 3));
            check("ws_lv", LineValid, 0);
            tick();
        end
        check("ws_lv13", LineValid, 1);
        check("ws_busy13", Busy, 1);
        check("ws_tag", LineTag, 28'h1);
        check("ws_line", DataLine, LINE_10);
        tick();
        check("ws_busy14", Busy, 0);

        // Miss during fill is ignored; held MissReq accepted in the IDLE cycle after DONE
        wait_n = 4'd0;
        MissAddress = 32'h10;
        MissReq = 1'b1;
        tick();
        MissAddress = 32'h64;
        for (int k = 0; k < 4; k++) begin
            check("ig_addr", MemAddress, exp_addr(32'h10, k));
            tick();
        end
        check("ig_lv", LineValid, 1);
        check("ig_tag", LineTag, 28'h1);
        check("ig_line", DataLine, LINE_10);
        tick();
        check("ig_idle_busy", Busy, 0);
        check("ig_idle_req", MemReadReq, 0);
        tick();
        MissReq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("re_addr", MemAddress, exp_addr(32'h64, k));
            tick();
        end
        check("re_lv", LineValid, 1);
        check("re_tag", LineTag, 28'h6);
        check("re_line", DataLine, LINE_60);
        tick();

        // Reset after two words of line 0x0
        MissAddress = 32'h0;
        MissReq = 1'b1;
        tick();
        MissReq = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_busy", Busy, 0);
        check("mr_req", MemReadReq, 0);
        check("mr_line", DataLine, 0);
        check("mr_tag", LineTag, 0);
        check("mr_addr", MemAddress, 0);
        check("mr_lv", LineValid, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mr_nolv", LineValid, 0);
        end
        MissReq = 1'b1;
        tick();
        MissReq = 1'b0;
        wait_valid(20, cyc);
        check("mr2_lat", cyc, 5);
        check("mr2_line", DataLine, LINE_00);
        check("mr2_tag", LineTag, 0);
        tick();

`ifdef MIPS_LINE_FILL_CRITICAL_WORD_FIRST_EN
        // Critical word first from 0x1D
        MissAddress = 32'h1D;
        MissReq = 1'b1;
        tick();
        MissReq = 1'b0;
        check("cw_cv1", CritValid, 0);
        check("cw_a0", MemAddress, 32'h1C);
        tick();
        check("cw_cv2", CritValid, 1);
        check("cw_word", CritWord, 32'h1F1E1D1C);
        check("cw_a1", MemAddress, 32'h10);
        tick();
        check("cw_cv3", CritValid, 0);
        check("cw_a2", MemAddress, 32'h14);
        tick();
        check("cw_a3", MemAddress, 32'h18);
        tick();
        check("cw_lv", LineValid, 1);
        check("cw_line", DataLine, LINE_10);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_line_fill.md
Name: mips_line_fill

Overview:
- Refill engine that sits directly upstream of the instruction cache's DataLine input.
- On a cache miss it fetches the 16-byte line containing the missed byte address from word-wide instruction memory, one word per memory handshake.
- It assembles the four words into a 128-bit line and presents it to the cache with a one-cycle valid pulse.
- Byte-addressed; line = 16 bytes = 4 x 32-bit words.

Parameters:
- ADDR_W, 32, byte-address width.
- LINE_WORDS, 4, words per line; line width = 32*LINE_WORDS; offset bits = log2(4*LINE_WORDS).

Ports:
- clockPulse  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- MissReq  input  1  cache reports a miss; sampled only in IDLE.
- MissAddress  input  ADDR_W  byte address that missed.
- Busy  output  1  high from the cycle after miss acceptance through the LineValid cycle.
- MemReadReq  output  1  memory read request; held until acknowledged.
- MemAddress  output  ADDR_W  word-aligned byte address of the current request.
- MemData  input  32  read data; valid only when MemAck=1.
- MemAck  input  1  one-cycle acknowledge; may be combinational from MemReadReq.
- DataLine  output  32*LINE_WORDS  assembled line; word k occupies bits [32k+31:32k].
- LineTag  output  ADDR_W-4  line base address bits [ADDR_W-1:4] of the filled line.
- LineValid  output  1  one-cycle pulse; DataLine and LineTag are stable from this cycle until the next fill starts.

Behaviour:
- Clock and reset: one clock, clockPulse. reset is synchronous and active-high; it is sampled only on a rising edge.
- Reset values: state=IDLE; Busy=0; MemReadReq=0; MemAddress=0; DataLine=0; LineTag=0; LineValid=0; word counter=0.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - If MissReq=1: latch base = {MissAddress[ADDR_W-1:4], 4'b0}, LineTag <= MissAddress[ADDR_W-1:4], counter <= 0.
  - Assert MemReadReq with MemAddress = base; go to FILL. Busy=1 from the next cycle.
- FILL:
  - MemReadReq stays high and MemAddress stays constant until MemAck=1.
  - On MemAck: DataLine word[counter] <= MemData.
  - If counter = LINE_WORDS-1: go to DONE and drop MemReadReq.
  - Otherwise: counter+1 and MemAddress <= base + 4*(counter+1). MemReadReq remains high, back-to-back.
- DONE: LineValid=1 for exactly one cycle; Busy=1; go to IDLE.
- Latency: with zero-wait memory (MemAck combinational), miss accepted at edge 0, words captured at edges 1..4, LineValid high in cycle 5. Each memory wait cycle adds one cycle.
- Words not yet written in the current fill keep their previous values. The cache must consume DataLine only on LineValid.
- MissReq while in FILL or DONE is ignored, with no queueing. The cache re-asserts MissReq after LineValid.
- MissReq in the IDLE cycle immediately following DONE is accepted normally.
- MemAck while MemReadReq=0 is ignored.
- MissAddress may change after acceptance without effect.
- Address arithmetic wraps modulo 2^ADDR_W; a line at the top of the address space fetches base..base+12 with no carry out.
- reset mid-fill: abort immediately and return to reset values. No LineValid; the partial line is discarded (DataLine=0).

Optional Feature:
- Macro: MIPS_LINE_FILL_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Fill starts at the missed word w = MissAddress[3:2].
  - Order: w, w+1, ..., wrapping mod LINE_WORDS. Each word is still written to DataLine slot = its own index.
  - Extra output CritValid (1 bit, reset 0) pulses one cycle after the first word is captured. CritWord (32 bits, reset 0) holds that word, so the cache may forward the instruction early.
  - LineValid timing is unchanged.
- Undefined: order always 0..LINE_WORDS-1; no CritValid/CritWord ports.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> all outputs 0; MemReadReq stays 0 for 10 cycles with MissReq=0.
- Zero-wait fill:
  - Stimulus: MissAddress=0x5, memory returns 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
  - Required: MemAddress sequence 0x0, 0x4, 0x8, 0xC; LineValid in cycle 5 after acceptance; DataLine=0x0F0E0D0C_0B0A0908_07060504_03020100; LineTag=0.
- Wait states: MissAddress=0x1A, MemAck delayed 2 cycles per word -> MemReadReq/MemAddress held (0x10, 0x14, 0x18, 0x1C); LineValid at cycle 13; LineTag=0x1; Busy high cycles 1-13.
- Ignored miss: MissReq=1 with MissAddress=0x64 during FILL of line 0x10 -> no change in addresses. After LineValid, re-asserted miss fetches 0x60..0x6C.
- Reset mid-fill: assert reset after 2 words of line 0x0 captured -> next cycle IDLE, DataLine=0, no LineValid pulse; a subsequent miss at 0x0 completes normally.
- With MIPS_LINE_FILL_CRITICAL_WORD_FIRST_EN, MissAddress=0x1D:
  - MemAddress sequence 0x1C, 0x10, 0x14, 0x18.
  - CritWord=0x1F1E1D1C pulse after the first ack.
  - Final DataLine identical to in-order fill.
